// File: rtl/archimedes_kbd_pkg.sv
// Shared codes, state encoding and arithmetic helpers for the
// Archimedes keyboard-side responder.
package archimedes_kbd_pkg;

    localparam logic [7:0] CMD_HRST = 8'hFF;
    localparam logic [7:0] CMD_RAK1 = 8'hFE;
    localparam logic [7:0] CMD_RAK2 = 8'hFD;
    localparam logic [7:0] CMD_RQID = 8'h20;
    localparam logic [7:0] CMD_PRST = 8'h21;
    localparam logic [7:0] CMD_RQMP = 8'h22;
    localparam logic [7:0] CMD_BACK = 8'h3F;
    localparam logic [7:0] CMD_NACK = 8'h30;
    localparam logic [7:0] CMD_SACK = 8'h31;
    localparam logic [7:0] CMD_MACK = 8'h32;
    localparam logic [7:0] CMD_SMAK = 8'h33;

    localparam logic [7:0] RSP_HRST = 8'hFF;
    localparam logic [7:0] RSP_RAK1 = 8'hFE;
    localparam logic [7:0] RSP_RAK2 = 8'hFD;

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_RAK1,
        ST_WAIT_RAK2,
        ST_WAIT_ACK,
        ST_IDLE,
        ST_WAIT_BACK,
        ST_WAIT_ACK2
    } state_t;

    typedef logic [3:0] rc_t;

    // NACK/SACK/MACK/SMAK are 0011_00xx
    function automatic logic is_ack(input logic [7:0] c);
        return c[7:2] == 6'b001100;
    endfunction

    function automatic logic is_leds(input logic [7:0] c);
        return c[7:3] == 5'b00000;
    endfunction

    // C0|n for press, D0|n for release
    function automatic logic [7:0] key_byte(input logic up, input rc_t n);
        return {3'b110, up, n};
    endfunction

    function automatic logic [9:0] sat10(input logic signed [11:0] v);
        if (v > 12'sd511)
            return 10'h1FF;
        if (v < -12'sd511)
            return 10'h201;
        return v[9:0];
    endfunction

    function automatic logic [7:0] clamp7(input logic signed [9:0] a);
        if (a > 10'sd63)
            return 8'h3F;
        if (a < -10'sd64)
            return 8'hC0;
        return a[7:0];
    endfunction

endpackage

// File: rtl/kbd_mouse_acc.sv
// Two saturating 10-bit mouse accumulators with report clamp and
// subtraction of the last reported deltas.
module kbd_mouse_acc
    import archimedes_kbd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] add_dx,
    input  logic [7:0] add_dy,
    input  logic       sub,
    input  logic [7:0] sub_dx,
    input  logic [7:0] sub_dy,
    output logic [7:0] rep_dx,
    output logic [7:0] rep_dy,
    output logic       nonzero
);

    logic [9:0]  acc_x;
    logic [9:0]  acc_y;
    logic [11:0] nx;
    logic [11:0] ny;

    function automatic logic [11:0] step(
        input logic [9:0] acc,
        input logic       a,
        input logic [7:0] av,
        input logic       s,
        input logic [7:0] sv
    );
        logic [11:0] v;
        v = {{2{acc[9]}}, acc};
        if (a)
            v = v + {{4{av[7]}}, av};
        if (s)
            v = v - {{4{sv[7]}}, sv};
        return v;
    endfunction

    assign nx = step(acc_x, add, add_dx, sub, sub_dx);
    assign ny = step(acc_y, add, add_dy, sub, sub_dy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_x <= '0;
            acc_y <= '0;
        end else if (clr) begin
            acc_x <= '0;
            acc_y <= '0;
        end else begin
            acc_x <= sat10(nx);
            acc_y <= sat10(ny);
        end
    end

    assign rep_dx  = clamp7(acc_x);
    assign rep_dy  = clamp7(acc_y);
    assign nonzero = |{acc_x, acc_y};

endmodule

// File: rtl/archimedes_kbd.sv
// Keyboard end of the IOC serial keyboard link: reset handshake,
// key/mouse reporting, ID and LED commands.
module archimedes_kbd
    import archimedes_kbd_pkg::*;
#(
    parameter int         TX_GAP = 16,
    parameter logic [5:0] KBD_ID = 6'h01
) (
    input  logic       clkcpu,
    input  logic       rst_i,
    input  logic [7:0] cmd_data,
    input  logic       cmd_strobe,
    output logic [7:0] rsp_data,
    output logic       rsp_strobe,
    input  logic       key_valid,
    input  logic       key_up,
    input  logic [3:0] key_row,
    input  logic [3:0] key_col,
    output logic       key_ready,
    input  logic       mouse_strobe,
    input  logic [7:0] mouse_dx,
    input  logic [7:0] mouse_dy,
    output logic [2:0] leds
);

    localparam logic [7:0] GAP = 8'(TX_GAP);

    state_t     state;
    logic [7:0] cnt;
    logic       rpl_pend;
    logic [7:0] rpl_byte;
    logic       scan_en;
    logic       mouse_en;
    logic       rqid_pend;
    logic       rqmp_pend;
    logic       key_full;
    logic       key_up_q;
    rc_t        key_row_q;
    rc_t        key_col_q;
    logic       msg_key;
    logic [7:0] byte2;
    logic [7:0] sent_dx;
    logic [7:0] sent_dy;

    logic [7:0] rep_dx;
    logic [7:0] rep_dy;
    logic       acc_nz;
    logic       acc_clr;
    logic       acc_sub;
    logic       past_ack;
    logic       key_go;
    logic       mouse_go;
    logic       have_data;

    assign past_ack  = state inside {ST_IDLE, ST_WAIT_BACK, ST_WAIT_ACK2};
    assign key_go    = key_full & scan_en;
    assign mouse_go  = acc_nz & mouse_en;
    assign have_data = rqid_pend | rqmp_pend | key_go | mouse_go;
    assign key_ready = ~key_full;

    assign acc_clr = cmd_strobe && cmd_data == CMD_HRST;
    assign acc_sub = cmd_strobe && state == ST_WAIT_ACK2
                  && is_ack(cmd_data) && !msg_key;

    kbd_mouse_acc u_acc (
        .clk     (clkcpu),
        .rst     (rst_i),
        .clr     (acc_clr),
        .add     (mouse_strobe & mouse_en),
        .add_dx  (mouse_dx),
        .add_dy  (mouse_dy),
        .sub     (acc_sub),
        .sub_dx  (sent_dx),
        .sub_dy  (sent_dy),
        .rep_dx  (rep_dx),
        .rep_dy  (rep_dy),
        .nonzero (acc_nz)
    );

    always_ff @(posedge clkcpu or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_RST;
            cnt        <= GAP;
            rpl_pend   <= 1'b0;
            rpl_byte   <= '0;
            rsp_data   <= '0;
            rsp_strobe <= 1'b0;
            leds       <= '0;
            scan_en    <= 1'b0;
            mouse_en   <= 1'b0;
            rqid_pend  <= 1'b0;
            rqmp_pend  <= 1'b0;
            key_full   <= 1'b0;
            key_up_q   <= 1'b0;
            key_row_q  <= '0;
            key_col_q  <= '0;
            msg_key    <= 1'b0;
            byte2      <= '0;
            sent_dx    <= '0;
            sent_dy    <= '0;
        end else begin
            rsp_strobe <= 1'b0;
            if (key_valid && !key_full && scan_en && past_ack) begin
                key_full  <= 1'b1;
                key_up_q  <= key_up;
                key_row_q <= key_row;
                key_col_q <= key_col;
            end
            if (cmd_strobe) begin
                cnt <= GAP;
                if (is_leds(cmd_data))
                    leds <= cmd_data[2:0];
                if (state != ST_RST && cmd_data == CMD_RQID)
                    rqid_pend <= 1'b1;
                if (state != ST_RST && cmd_data == CMD_RQMP)
                    rqmp_pend <= 1'b1;
                if (cmd_data == CMD_HRST) begin
                    state     <= ST_WAIT_RAK1;
                    rpl_pend  <= 1'b1;
                    rpl_byte  <= RSP_HRST;
                    key_full  <= 1'b0;
                    scan_en   <= 1'b0;
                    mouse_en  <= 1'b0;
                    rqid_pend <= 1'b0;
                    rqmp_pend <= 1'b0;
                end else begin
                    unique case (state)
                        ST_WAIT_RAK1: begin
                            if (cmd_data == CMD_RAK1) begin
                                rpl_pend <= 1'b1;
                                rpl_byte <= RSP_RAK1;
                                state    <= ST_WAIT_RAK2;
                            end else if (!is_leds(cmd_data)) begin
                                rpl_pend <= 1'b1;
                                rpl_byte <= RSP_HRST;
                            end
                        end
                        ST_WAIT_RAK2: begin
                            if (cmd_data == CMD_RAK2) begin
                                rpl_pend <= 1'b1;
                                rpl_byte <= RSP_RAK2;
                                state    <= ST_WAIT_ACK;
                            end else if (!is_leds(cmd_data)) begin
                                rpl_pend <= 1'b1;
                                rpl_byte <= RSP_HRST;
                                state    <= ST_WAIT_RAK1;
                            end
                        end
                        ST_WAIT_ACK: begin
                            if (is_ack(cmd_data)) begin
                                scan_en  <= cmd_data[0];
                                mouse_en <= cmd_data[1];
                                state    <= ST_IDLE;
                            end
                        end
                        ST_WAIT_BACK: begin
                            if (cmd_data == CMD_BACK) begin
                                rpl_pend <= 1'b1;
                                rpl_byte <= byte2;
                                state    <= ST_WAIT_ACK2;
                            end else if (is_ack(cmd_data)) begin
                                scan_en  <= cmd_data[0];
                                mouse_en <= cmd_data[1];
                                state    <= ST_IDLE;
                            end
                        end
                        ST_WAIT_ACK2: begin
                            if (is_ack(cmd_data)) begin
                                scan_en  <= cmd_data[0];
                                mouse_en <= cmd_data[1];
                                state    <= ST_IDLE;
                                if (msg_key)
                                    key_full <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (cnt == 8'd1) begin
                cnt <= '0;
                if (state == ST_RST) begin
                    rsp_data   <= RSP_HRST;
                    rsp_strobe <= 1'b1;
                    state      <= ST_WAIT_RAK1;
                end else if (rpl_pend) begin
                    rsp_data   <= rpl_byte;
                    rsp_strobe <= 1'b1;
                    rpl_pend   <= 1'b0;
                end else if (state == ST_IDLE) begin
                    // ID first, then forced mouse, key, spontaneous mouse
                    if (rqid_pend) begin
                        rsp_data   <= {2'b10, KBD_ID};
                        rsp_strobe <= 1'b1;
                        rqid_pend  <= 1'b0;
                    end else if (key_go && !rqmp_pend) begin
                        rsp_data   <= key_byte(key_up_q, key_row_q);
                        rsp_strobe <= 1'b1;
                        byte2      <= key_byte(key_up_q, key_col_q);
                        msg_key    <= 1'b1;
                        state      <= ST_WAIT_BACK;
                    end else if (rqmp_pend || mouse_go) begin
                        rsp_data   <= {1'b0, rep_dx[6:0]};
                        rsp_strobe <= 1'b1;
                        byte2      <= {1'b0, rep_dy[6:0]};
                        sent_dx    <= rep_dx;
                        sent_dy    <= rep_dy;
                        msg_key    <= 1'b0;
                        rqmp_pend  <= 1'b0;
                        state      <= ST_WAIT_BACK;
                    end
                end
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end else if (state == ST_IDLE && have_data) begin
                cnt <= GAP;
            end
        end
    end

endmodule

// File: tb/tb_archimedes_kbd.sv
// Scoreboard bench for archimedes_kbd: expected reply bytes are queued
// as stimulus is driven and checked as rsp_strobe pulses arrive.
module tb_archimedes_kbd;

    localparam int GAP = 16;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] cmd_data;
    logic       cmd_strobe;
    logic [7:0] rsp_data;
    logic       rsp_strobe;
    logic       key_valid;
    logic       key_up;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic       key_ready;
    logic       mouse_strobe;
    logic [7:0] mouse_dx;
    logic [7:0] mouse_dy;
    logic [2:0] leds;

    int n_chk = 0;
    int n_fail = 0;
    int n_rx = 0;
    int cyc = 0;
    int cmd_cyc = 0;
    int last_rx_cyc = 0;
    int mx = 0;
    int my = 0;
    logic [7:0] exp_q[$];

    archimedes_kbd #(.TX_GAP(GAP), .KBD_ID(6'h01)) dut (
        .clkcpu       (clk),
        .rst_i        (rst_i),
        .cmd_data     (cmd_data),
        .cmd_strobe   (cmd_strobe),
        .rsp_data     (rsp_data),
        .rsp_strobe   (rsp_strobe),
        .key_valid    (key_valid),
        .key_up       (key_up),
        .key_row      (key_row),
        .key_col      (key_col),
        .key_ready    (key_ready),
        .mouse_strobe (mouse_strobe),
        .mouse_dx     (mouse_dx),
        .mouse_dy     (mouse_dy),
        .leds         (leds)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_i && rsp_strobe) begin
            n_rx++;
            last_rx_cyc = cyc;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got %02h, none expected", rsp_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rsp_data !== e) begin
                    n_fail++;
                    $display("FAIL rsp_byte: got %02h, expected %02h", rsp_data, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sat(input int v);
        if (v > 511) return 511;
        if (v < -511) return -511;
        return v;
    endfunction

    function automatic int clampr(input int v);
        if (v > 63) return 63;
        if (v < -64) return -64;
        return v;
    endfunction

    function automatic logic [7:0] enc(input int v);
        logic [7:0] b;
        b = 8'(clampr(v));
        return b & 8'h7F;
    endfunction

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk);
        cmd_data = c;
        cmd_strobe = 1'b1;
        @(negedge clk);
        cmd_strobe = 1'b0;
        cmd_cyc = cyc;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_timeout: %0d replies missing, first %02h",
                     exp_q.size(), exp_q[0]);
            exp_q.delete();
        end
    endtask

    task automatic cmd_rsp(input logic [7:0] c, input logic [7:0] r);
        exp_q.push_back(r);
        send_cmd(c);
        wait_drain(3 * GAP);
    endtask

    task automatic offer_key(input logic up, input logic [3:0] r,
                             input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_up = up;
        key_row = r;
        key_col = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic mouse_burst(input int n, input int dx, input int dy);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mouse_strobe = 1'b1;
            mouse_dx = 8'(dx);
            mouse_dy = 8'(dy);
            mx = sat(mx + dx);
            my = sat(my + dy);
        end
        @(negedge clk);
        mouse_strobe = 1'b0;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int n0;
        n0 = n_rx;
        repeat (cycles) @(negedge clk);
        n_chk++;
        if (n_rx !== n0) begin
            n_fail++;
            $display("FAIL %s: %0d strobes seen, expected 0", name, n_rx - n0);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cmd_data = '0;
        cmd_strobe = 1'b0;
        key_valid = 1'b0;
        key_up = 1'b0;
        key_row = '0;
        key_col = '0;
        mouse_strobe = 1'b0;
        mouse_dx = '0;
        mouse_dy = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (rsp_strobe !== 1'b0 || rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rsp: got %b/%02h, expected 0/00", rsp_strobe, rsp_data);
        end
        n_chk++;
        if (leds !== 3'b000 || key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_io: leds %b ready %b, expected 000/1", leds, key_ready);
        end
        exp_q.push_back(8'hFF);
        rst_i = 1'b0;
        cmd_cyc = cyc;
        wait_drain(3 * GAP);
        n_chk++;
        if (last_rx_cyc - cmd_cyc !== GAP) begin
            n_fail++;
            $display("FAIL reset_latency: got %0d, expected %0d", last_rx_cyc - cmd_cyc, GAP);
        end
    endtask

    task automatic test_early_key();
        offer_key(1'b0, 4'd1, 4'd1);
        n_chk++;
        if (key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL early_key_drop: key_ready %b, expected 1", key_ready);
        end
    endtask

    task automatic test_leds_early();
        send_cmd(8'h02);
        n_chk++;
        if (leds !== 3'b010) begin
            n_fail++;
            $display("FAIL leds_rak1: got %b, expected 010", leds);
        end
        expect_quiet("leds_rak1_quiet", 3 * GAP);
    endtask

    task automatic test_handshake(input logic [7:0] ack);
        cmd_rsp(8'hFE, 8'hFE);
        n_chk++;
        if (last_rx_cyc - cmd_cyc !== GAP) begin
            n_fail++;
            $display("FAIL rak1_latency: got %0d, expected %0d", last_rx_cyc - cmd_cyc, GAP);
        end
        cmd_rsp(8'hFD, 8'hFD);
        send_cmd(ack);
    endtask

    task automatic test_key();
        offer_key(1'b0, 4'd3, 4'd5);
        n_chk++;
        if (key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL key_accept: key_ready %b, expected 0", key_ready);
        end
        exp_q.push_back(8'hC3);
        wait_drain(3 * GAP);
        cmd_rsp(8'h3F, 8'hC5);
        n_chk++;
        if (last_rx_cyc - cmd_cyc !== GAP || key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL key_back: latency %0d ready %b, expected %0d/0",
                     last_rx_cyc - cmd_cyc, key_ready, GAP);
        end
        send_cmd(8'h31);
        n_chk++;
        if (key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL key_release: key_ready %b, expected 1", key_ready);
        end
    endtask

    task automatic test_leds();
        send_cmd(8'h05);
        n_chk++;
        if (leds !== 3'b101) begin
            n_fail++;
            $display("FAIL leds_idle: got %b, expected 101", leds);
        end
        expect_quiet("leds_quiet", 3 * GAP);
        send_cmd(8'h21);
        expect_quiet("prst_quiet", 3 * GAP);
        n_chk++;
        if (leds !== 3'b101) begin
            n_fail++;
            $display("FAIL leds_hold: got %b, expected 101", leds);
        end
    endtask

    task automatic mouse_round();
        exp_q.push_back(enc(mx));
        wait_drain(4 * GAP);
        cmd_rsp(8'h3F, enc(my));
        send_cmd(8'h32);
        mx = mx - clampr(mx);
        my = my - clampr(my);
    endtask

    task automatic test_mouse();
        cmd_rsp(8'hFF, 8'hFF);
        mx = 0;
        my = 0;
        test_handshake(8'h32);
        mouse_burst(5, 20, 0);
        mouse_round();
        exp_q.push_back(enc(mx));
        wait_drain(3 * GAP);
        n_chk++;
        if (last_rx_cyc - cmd_cyc !== GAP) begin
            n_fail++;
            $display("FAIL mouse_resid_latency: got %0d, expected %0d",
                     last_rx_cyc - cmd_cyc, GAP);
        end
        cmd_rsp(8'h3F, enc(my));
        send_cmd(8'h32);
        mx = mx - clampr(mx);
        my = my - clampr(my);
        expect_quiet("mouse_drained", 3 * GAP);
        mouse_burst(5, 0, -128);
        for (int r = 0; r < 20; r++) begin
            if (mx == 0 && my == 0) break;
            mouse_round();
        end
        expect_quiet("mouse_sat_drained", 3 * GAP);
    endtask

    task automatic test_rqid();
        cmd_rsp(8'hFF, 8'hFF);
        test_handshake(8'h33);
        offer_key(1'b0, 4'd1, 4'd2);
        exp_q.push_back(8'hC1);
        wait_drain(3 * GAP);
        cmd_rsp(8'h3F, 8'hC2);
        send_cmd(8'h20);
        expect_quiet("rqid_in_ack2", 2 * GAP);
        send_cmd(8'h33);
        offer_key(1'b0, 4'd7, 4'd9);
        n_chk++;
        if (key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL key2_accept: key_ready %b, expected 0", key_ready);
        end
        exp_q.push_back(8'h81);
        wait_drain(3 * GAP);
        n_chk++;
        if (last_rx_cyc - cmd_cyc !== GAP) begin
            n_fail++;
            $display("FAIL kbid_latency: got %0d, expected %0d", last_rx_cyc - cmd_cyc, GAP);
        end
        exp_q.push_back(8'hC7);
        wait_drain(3 * GAP);
        cmd_rsp(8'h3F, 8'hC9);
        send_cmd(8'h31);
    endtask

    task automatic test_hrst_abort();
        cmd_rsp(8'hFF, 8'hFF);
        test_handshake(8'h31);
        offer_key(1'b1, 4'd2, 4'd4);
        exp_q.push_back(8'hD2);
        wait_drain(3 * GAP);
        exp_q.push_back(8'hFF);
        send_cmd(8'hFF);
        n_chk++;
        if (key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hrst_key_clear: key_ready %b, expected 1", key_ready);
        end
        wait_drain(3 * GAP);
        cmd_rsp(8'hFE, 8'hFE);
        expect_quiet("hrst_no_key_rak2", 3 * GAP);
        cmd_rsp(8'hFD, 8'hFD);
        send_cmd(8'h31);
        expect_quiet("hrst_no_key_idle", 3 * GAP);
    endtask

    task automatic test_async_reset();
        send_cmd(8'h07);
        send_cmd(8'hFF);
        repeat (4) @(negedge clk);
        #2;
        rst_i = 1'b1;
        exp_q.delete();
        #1;
        n_chk++;
        if (leds !== 3'b000 || rsp_data !== 8'h00 || key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: leds %b data %02h ready %b, expected 000/00/1",
                     leds, rsp_data, key_ready);
        end
        repeat (2) @(negedge clk);
        exp_q.push_back(8'hFF);
        rst_i = 1'b0;
        cmd_cyc = cyc;
        wait_drain(3 * GAP);
        n_chk++;
        if (last_rx_cyc - cmd_cyc !== GAP) begin
            n_fail++;
            $display("FAIL reset2_latency: got %0d, expected %0d", last_rx_cyc - cmd_cyc, GAP);
        end
    endtask

    initial begin
        test_reset();
        test_early_key();
        test_leds_early();
        test_handshake(8'h33);
        test_key();
        test_leds();
        test_mouse();
        test_rqid();
        test_hrst_abort();
        test_async_reset();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/archimedes_kbd.md
# archimedes_kbd

Keyboard-side responder for the Archimedes serial keyboard protocol. It sits at the far end of the IOC keyboard link: it consumes the command bytes the IOC transmits and produces the reply bytes the IOC receives. It runs the reset handshake, key up/down reporting, mouse reporting, ID and LED commands. Key and mouse events come from the board's PS/2 front end through a ready/valid port and a delta port.

## Interface
- `TX_GAP`, default 16: clkcpu cycles between the accepting event (command strobe, or state ready with data pending) and a reply strobe; range 1..255.
- `KBD_ID`, default 6'h01: keyboard ID returned in the KBID reply.
- `clkcpu` in 1: system clock, single clock domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cmd_data` in 8: command byte from the IOC (IOC kbd_out_data).
- `cmd_strobe` in 1: one-cycle pulse; `cmd_data` is valid.
- `rsp_data` out 8: reply byte to the IOC (IOC kbd_in_data).
- `rsp_strobe` out 1: one-cycle pulse; `rsp_data` is valid and held until the next strobe.
- `key_valid` in 1: key event offered.
- `key_up` in 1: 1 = release, 0 = press.
- `key_row` in 4: matrix row.
- `key_col` in 4: matrix column.
- `key_ready` out 1: holding register empty; event accepted when `key_valid & key_ready`.
- `mouse_strobe` in 1: one-cycle pulse; add the deltas.
- `mouse_dx` in 8: signed X delta.
- `mouse_dy` in 8: signed Y delta.
- `leds` out 3: LED state from the last LEDS command; bit0 caps, bit1 num, bit2 scroll.

## Operation
- Command codes: HRST FF, RAK1 FE, RAK2 FD, RQID 20, PRST 21, RQMP 22, BACK 3F, NACK 30, SACK 31, MACK 32, SMAK 33, LEDS 00-07.
- Reply codes:
  - HRST FF, RAK1 FE, RAK2 FD.
  - KBID = {2'b10, KBID_ID}.
  - Key down: C0|row, then C0|col.
  - Key up: D0|row, then D0|col.
  - Mouse: {1'b0, dx[6:0]}, then {1'b0, dy[6:0]}.
- FSM states: RST, WAIT_RAK1, WAIT_RAK2, WAIT_ACK, IDLE, WAIT_BACK, WAIT_ACK2.
- RST:
  - Entered at reset.
  - Emits FF once, after TX_GAP cycles, then goes to WAIT_RAK1.
- HRST received in any state:
  - Aborts any message in progress.
  - Clears the holding register, mouse accumulators and enables.
  - Replies FF, then goes to WAIT_RAK1.
- WAIT_RAK1: on RAK1, reply FE and go to WAIT_RAK2. Any other byte: reply FF and stay.
- WAIT_RAK2: on RAK2, reply FD and go to WAIT_ACK. Any other byte: reply FF and go to WAIT_RAK1.
- WAIT_ACK:
  - On NACK/SACK/MACK/SMAK: load enables, scan = code[0], mouse = code[1]; go to IDLE.
  - Other bytes are ignored.
- IDLE, priority order when the gap counter expires:
  1. Pending RQID.
  2. Pending RQMP.
  3. Key held with scan enabled.
  4. Accumulator nonzero with mouse enabled.
- KBID is a single byte and the FSM stays in IDLE. Every two-byte message sends byte 1 and goes to WAIT_BACK.
- RQMP sends a mouse report even when both deltas are 0 and mouse is disabled.
- WAIT_BACK:
  - On BACK: send byte 2 and go to WAIT_ACK2.
  - On an ack code: abandon the message, reload enables, go to IDLE; the key stays held.
- WAIT_ACK2:
  - On NACK/SACK/MACK/SMAK: reload enables and go to IDLE.
  - A sent key frees the holding register; a sent mouse report subtracts the reported deltas.
- RQID, RQMP: latched as pending in any non-reset state; serviced from IDLE.
- LEDS: `leds <= cmd_data[2:0]` in any state; no reply.
- PRST and unknown codes: ignored.
- Key input:
  - Accepted whenever the holding register is empty.
  - Dropped (register stays empty) while scan is disabled or the FSM is not yet past WAIT_ACK.
- Mouse accumulators:
  - 10-bit signed, saturate at ±511.
  - Ignored while mouse is disabled.
  - Report value = accumulator clamped to -64..+63; the same value is subtracted after WAIT_ACK2.
  - A simultaneous strobe and subtraction net both.

## Timing
- Reset values:
  - rsp_data 00, rsp_strobe 0, leds 000, enables 0.
  - key_ready 1, accumulators 0, pending flags 0, state RST.
- Reply latency: exactly TX_GAP cycles from the command strobe to `rsp_strobe`.
- Spontaneous send from IDLE: TX_GAP cycles after entering IDLE with data present.
- Any command strobe restarts the gap counter.
- At most one reply is outstanding; no strobe while the gap counter is running.
- `key_ready` falls the cycle after acceptance. It rises the cycle after the WAIT_ACK2 ack, or immediately on HRST.
- `rst_i` asserted mid-message: all state clears asynchronously; no further strobe until RST re-times TX_GAP.

## Structure
- Shared package `archimedes_kbd_pkg`: command/reply code constants, state enum, 4-bit row/col typedef.
- One sub-module, `kbd_mouse_acc`: two saturating accumulators with clamp and subtract.

## Test plan
- Reset release: FF at cycle TX_GAP. Send FE: reply FE. Send FD: reply FD. Send 33: enables = 11.
- With SACK, key row 3 col 5 pressed: reply C3. Send BACK: reply C5. Send SACK: key_ready rises.
- With MACK, five strobes of dx = +20: reply 3F (63). Send BACK: reply 00. Send MACK: residual 37 produces a second report of 25 after TX_GAP.
- Send RQID during WAIT_ACK2, then SMAK: reply 81 before any pending key.
- HRST while in WAIT_BACK: reply FF and the held key is discarded. Send FE: reply FE, and no key message follows.
- Send 05 in any state: leds = 101, no rsp_strobe. Send 21: nothing happens.
